// File: rtl/mcore_dma_copy_initiator.sv
// Domain-tagged DMA copy initiator: copies nwords words src->dst, one read then one write per word.
// Optional response checking (type/opaque/domain -> sticky error) enabled by MCORE_DMA_RESPCHK_EN.
module mcore_dma_copy_initiator #(
    parameter int unsigned p_opaque_nbits = 8,
    parameter int unsigned p_addr_nbits   = 32,
    parameter int unsigned p_data_nbits   = 32,
    parameter int unsigned p_cnt_nbits    = 16,
    localparam int unsigned LEN_W  = $clog2(p_data_nbits / 8),
    localparam int unsigned REQ_W  = 3 + p_opaque_nbits + p_addr_nbits + LEN_W,
    localparam int unsigned RESP_W = 3 + p_opaque_nbits + LEN_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_val,
    output logic                    cmd_rdy,
    input  logic [p_addr_nbits-1:0] cmd_src,
    input  logic [p_addr_nbits-1:0] cmd_dst,
    input  logic [p_cnt_nbits-1:0]  cmd_nwords,
    input  logic                    cmd_domain,
    output logic                    done,
    output logic                    error,
    output logic                    memreq_val,
    input  logic                    memreq_rdy,
    output logic [REQ_W-1:0]        memreq_control,
    output logic [p_data_nbits-1:0] memreq_data,
    output logic                    memreq_domain,
    input  logic                    memresp_val,
    output logic                    memresp_rdy,
    input  logic [RESP_W-1:0]       memresp_control,
    input  logic [p_data_nbits-1:0] memresp_data,
    input  logic                    memresp_domain
);
    localparam logic [2:0] TYPE_RD = 3'd0;
    localparam logic [2:0] TYPE_WR = 3'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_FIN
    } state_e;

    state_e                  state_q, state_n;
    logic [p_addr_nbits-1:0] src_q, src_n;
    logic [p_addr_nbits-1:0] dst_q, dst_n;
    logic [p_cnt_nbits-1:0]  nwords_q, nwords_n;
    logic [p_cnt_nbits-1:0]  idx_q, idx_n;
    logic                    domain_q, domain_n;
    logic [p_data_nbits-1:0] buf_q, buf_n;
    logic                    error_q, error_n;
    logic                    resp_bad_c;

    logic                    cmd_rdy_n, done_n, req_val_n, resp_rdy_n;
    logic                    req_is_wr_c;
    logic [p_addr_nbits-1:0] req_addr_c;
    logic [REQ_W-1:0]        req_ctrl_n;
    logic [p_data_nbits-1:0] req_data_n;

`ifdef MCORE_DMA_RESPCHK_EN
    // Response must echo the issued type, the word-index opaque and the transfer domain.
    logic [2:0]                resp_type_c;
    logic [2:0]                resp_exp_type_c;
    logic [p_opaque_nbits-1:0] resp_opaque_c;
    logic                      unused_resp_len;

    assign resp_type_c     = memresp_control[RESP_W-1 -: 3];
    assign resp_opaque_c   = memresp_control[LEN_W +: p_opaque_nbits];
    assign resp_exp_type_c = (state_q == ST_WR_RESP) ? TYPE_WR : TYPE_RD;
    assign unused_resp_len = ^memresp_control[LEN_W-1:0];
    assign resp_bad_c      = memresp_val
                           && ((state_q == ST_RD_RESP) || (state_q == ST_WR_RESP))
                           && ((resp_type_c != resp_exp_type_c)
                               || (resp_opaque_c != idx_q[p_opaque_nbits-1:0])
                               || (memresp_domain != domain_q));
`else
    logic unused_resp;

    assign unused_resp = ^{memresp_control, memresp_domain};
    assign resp_bad_c  = 1'b0;
`endif

    // Next state, datapath updates and next-cycle output values.
    always_comb begin
        state_n  = state_q;
        src_n    = src_q;
        dst_n    = dst_q;
        nwords_n = nwords_q;
        idx_n    = idx_q;
        domain_n = domain_q;
        buf_n    = buf_q;
        error_n  = error_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_val) begin
                    src_n    = cmd_src;
                    dst_n    = cmd_dst;
                    nwords_n = cmd_nwords;
                    domain_n = cmd_domain;
                    idx_n    = '0;
                    error_n  = 1'b0;
                    state_n  = (cmd_nwords == '0) ? ST_FIN : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (memreq_rdy) state_n = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (memresp_val) begin
                    buf_n   = memresp_data;
                    state_n = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                if (memreq_rdy) state_n = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (memresp_val) begin
                    if (p_cnt_nbits'(idx_q + p_cnt_nbits'(1)) == nwords_q) begin
                        state_n = ST_FIN;
                    end else begin
                        idx_n   = p_cnt_nbits'(idx_q + p_cnt_nbits'(1));
                        state_n = ST_RD_REQ;
                    end
                end
            end
            ST_FIN: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (resp_bad_c) error_n = 1'b1;

        // Outputs are registered from next-state values so a stalled request holds every field.
        cmd_rdy_n   = (state_n == ST_IDLE);
        done_n      = (state_n == ST_FIN);
        req_val_n   = (state_n == ST_RD_REQ) || (state_n == ST_WR_REQ);
        resp_rdy_n  = (state_n == ST_IDLE) || (state_n == ST_RD_RESP) || (state_n == ST_WR_RESP);
        req_is_wr_c = (state_n == ST_WR_REQ);
        req_addr_c  = (req_is_wr_c ? dst_n : src_n) + (p_addr_nbits'(idx_n) << LEN_W);
        req_ctrl_n  = {req_is_wr_c ? TYPE_WR : TYPE_RD, idx_n[p_opaque_nbits-1:0], req_addr_c, LEN_W'(0)};
        req_data_n  = req_is_wr_c ? buf_n : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            src_q          <= '0;
            dst_q          <= '0;
            nwords_q       <= '0;
            idx_q          <= '0;
            domain_q       <= 1'b0;
            buf_q          <= '0;
            error_q        <= 1'b0;
            cmd_rdy        <= 1'b1;
            done           <= 1'b0;
            memreq_val     <= 1'b0;
            memreq_control <= '0;
            memreq_data    <= '0;
            memresp_rdy    <= 1'b1;
        end else begin
            state_q        <= state_n;
            src_q          <= src_n;
            dst_q          <= dst_n;
            nwords_q       <= nwords_n;
            idx_q          <= idx_n;
            domain_q       <= domain_n;
            buf_q          <= buf_n;
            error_q        <= error_n;
            cmd_rdy        <= cmd_rdy_n;
            done           <= done_n;
            memreq_val     <= req_val_n;
            memreq_control <= req_ctrl_n;
            memreq_data    <= req_data_n;
            memresp_rdy    <= resp_rdy_n;
        end
    end

    assign memreq_domain = domain_q;
    assign error         = error_q;

endmodule

// File: tb/tb_mcore_dma_copy_initiator.sv
// Bench for mcore_dma_copy_initiator: memory model plus a transaction-level copy reference.
module tb_mcore_dma_copy_initiator;
    localparam int unsigned O  = 8;
    localparam int unsigned A  = 32;
    localparam int unsigned D  = 32;
    localparam int unsigned C  = 16;
    localparam int unsigned L  = 2;
    localparam int unsigned CW = 3 + O + A + L;
    localparam int unsigned RW = 3 + O + L;

`ifdef MCORE_DMA_RESPCHK_EN
    localparam logic BAD_DOM_ERR = 1'b1;
`else
    localparam logic BAD_DOM_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_val, cmd_rdy, cmd_domain;
    logic [A-1:0]  cmd_src, cmd_dst;
    logic [C-1:0]  cmd_nwords;
    logic          done, error;
    logic          memreq_val, memreq_rdy, memreq_domain;
    logic [CW-1:0] memreq_control;
    logic [D-1:0]  memreq_data;
    logic          memresp_val, memresp_rdy, memresp_domain;
    logic [RW-1:0] memresp_control;
    logic [D-1:0]  memresp_data;

    always #5 clk = ~clk;

    mcore_dma_copy_initiator dut (
        .clk(clk), .reset(reset),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
        .cmd_nwords(cmd_nwords), .cmd_domain(cmd_domain),
        .done(done), .error(error),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_control(memreq_control),
        .memreq_data(memreq_data), .memreq_domain(memreq_domain),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_control(memresp_control),
        .memresp_data(memresp_data), .memresp_domain(memresp_domain)
    );

    typedef struct { logic wr; logic [A-1:0] addr; logic [O-1:0] opq; logic [D-1:0] data; } req_t;
    typedef struct { logic wr; logic [O-1:0] opq; logic [D-1:0] data; int delay; } resp_t;

    req_t          exp_q[$];
    resp_t         resp_q[$];
    logic [D-1:0]  mem     [logic [A-1:0]];
    logic [D-1:0]  ref_mem [logic [A-1:0]];

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0, done_cnt = 0, done_cyc = 0, acc_cyc = 0, done0 = 0;
    int            rdy_pct = 100, max_delay = 0, stall_wr = 0;
    bit            hold_resp = 0;
    logic          bad_dom = 1'b0;
    logic          cur_dom = 1'b0;
    logic          hold_v = 1'b0;
    logic [CW-1:0] hold_ctrl;
    logic [D-1:0]  hold_data;
    logic          hold_dom;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [D-1:0] mem_rd(input logic [A-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC0DE_F00D;
    endfunction

    function automatic logic [D-1:0] ref_rd(input logic [A-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a ^ 32'hC0DE_F00D;
    endfunction

    // One clock: observe at negedge, act as memory, drive inputs for the next posedge.
    task automatic step();
        resp_t        r;
        req_t         e;
        logic [A-1:0] a;
        @(negedge clk);
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (reset && hold_v && memreq_val) begin
            check("hold_ctrl", 64'(memreq_control), 64'(hold_ctrl));
            check("hold_data", 64'(memreq_data), 64'(hold_data));
            check("hold_dom", 64'(memreq_domain), 64'(hold_dom));
        end

        memresp_val = 1'b0;
        if (reset && !hold_resp && resp_q.size() > 0) begin
            r = resp_q[0];
            if (r.delay > 0) begin
                r.delay = r.delay - 1;
                resp_q[0] = r;
            end else begin
                memresp_val     = 1'b1;
                memresp_control = {3'(r.wr), r.opq, 2'b00};
                memresp_data    = r.data;
                memresp_domain  = cur_dom ^ bad_dom;
                if (memresp_rdy) begin
                    void'(resp_q.pop_front());
                    bad_dom = 1'b0;
                end
            end
        end

        memreq_rdy = ($urandom_range(99) < rdy_pct);
        if (memreq_val && memreq_control[CW-1 -: 3] == 3'd1 && stall_wr > 0) begin
            memreq_rdy = 1'b0;
            stall_wr--;
        end
        hold_v    = reset && memreq_val && !memreq_rdy;
        hold_ctrl = memreq_control;
        hold_data = memreq_data;
        hold_dom  = memreq_domain;

        if (reset && memreq_val && memreq_rdy) begin
            if (exp_q.size() == 0) begin
                check("unexp_req", 64'(memreq_val), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("req_ctrl", 64'(memreq_control), 64'({3'(e.wr), e.opq, e.addr, 2'b00}));
                check("req_data", 64'(memreq_data), 64'(e.data));
                check("req_dom", 64'(memreq_domain), 64'(cur_dom));
            end
            a       = memreq_control[L +: A];
            r.wr    = (memreq_control[CW-1 -: 3] == 3'd1);
            r.opq   = memreq_control[L+A +: O];
            r.delay = int'($urandom_range(max_delay));
            if (r.wr) begin
                mem[a] = memreq_data;
                r.data = '0;
            end else begin
                r.data = mem_rd(a);
            end
            resp_q.push_back(r);
        end
    endtask

    // Build the expected transaction list from the copy rule and hand the command over.
    task automatic start_cmd(input logic [A-1:0] src, input logic [A-1:0] dst, input int n, input logic dom);
        req_t         e;
        logic [A-1:0] ra, wa;
        logic [D-1:0] v;
        logic         acc;
        ref_mem = mem;
        for (int i = 0; i < n; i++) begin
            ra = src + A'(4 * i);
            wa = dst + A'(4 * i);
            v  = ref_rd(ra);
            e.wr = 1'b0; e.addr = ra; e.opq = O'(i); e.data = '0;
            exp_q.push_back(e);
            e.wr = 1'b1; e.addr = wa; e.opq = O'(i); e.data = v;
            exp_q.push_back(e);
            ref_mem[wa] = v;
        end
        cur_dom    = dom;
        cmd_src    = src;
        cmd_dst    = dst;
        cmd_nwords = C'(n);
        cmd_domain = dom;
        cmd_val    = 1'b1;
        done0      = done_cnt;
        acc        = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) begin
            acc     = cmd_rdy;
            acc_cyc = cyc;
            step();
        end
        cmd_val = 1'b0;
        check("cmd_accept", 64'(acc), 64'(1));
        check("err_clear", 64'(error), 64'(0));
    endtask

    task automatic finish_cmd(input logic [A-1:0] dst, input int n, input bit ideal, input logic exp_err);
        logic [A-1:0] wa;
        for (int k = 0; k < 3000 && done_cnt == done0; k++) begin
            check("busy_cmd_rdy", 64'(cmd_rdy), 64'(0));
            cmd_val    = 1'($urandom_range(1));
            cmd_src    = $urandom;
            cmd_dst    = $urandom;
            cmd_nwords = C'($urandom);
            cmd_domain = 1'($urandom_range(1));
            step();
        end
        cmd_val = 1'b0;
        if (ideal && done_cnt > done0)
            check("done_latency", 64'(done_cyc - acc_cyc), 64'(4 * n + 1));
        repeat (4) step();
        check("done_pulses", 64'(done_cnt - done0), 64'(1));
        check("exp_left", 64'(exp_q.size()), 64'(0));
        check("resp_left", 64'(resp_q.size()), 64'(0));
        check("error", 64'(error), 64'(exp_err));
        check("idle_rdy", 64'(cmd_rdy), 64'(1));
        for (int i = 0; i < n; i++) begin
            wa = dst + A'(4 * i);
            check("dst_word", 64'(mem_rd(wa)), 64'(ref_rd(wa)));
        end
        exp_q.delete();
        resp_q.delete();
    endtask

    task automatic run_cmd(input logic [A-1:0] src, input logic [A-1:0] dst, input int n,
                           input logic dom, input bit ideal, input logic exp_err);
        if (ideal) begin
            rdy_pct   = 100;
            max_delay = 0;
        end
        start_cmd(src, dst, n, dom);
        finish_cmd(dst, n, ideal, exp_err);
    endtask

    initial begin
        reset = 1'b0; cmd_val = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_nwords = '0; cmd_domain = 1'b0;
        memreq_rdy = 1'b0; memresp_val = 1'b0; memresp_control = '0; memresp_data = '0; memresp_domain = 1'b0;
        repeat (2) step();
        check("rst_memreq_val", 64'(memreq_val), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        check("rst_cmd_rdy", 64'(cmd_rdy), 64'(1));
        check("rst_memresp_rdy", 64'(memresp_rdy), 64'(1));
        reset = 1'b1;
        step();

        // Basic three-word copy with ideal memory.
        mem[32'h0] = 32'hA; mem[32'h4] = 32'hB; mem[32'h8] = 32'hC;
        run_cmd(32'h0, 32'h100, 3, 1'b0, 1'b1, 1'b0);
        check("copy_w0", 64'(mem_rd(32'h100)), 64'(32'hA));
        check("copy_w1", 64'(mem_rd(32'h104)), 64'(32'hB));
        check("copy_w2", 64'(mem_rd(32'h108)), 64'(32'hC));

        // Zero-length command: no requests, immediate done.
        run_cmd(32'h40, 32'h80, 0, 1'b0, 1'b1, 1'b0);

        // Write-request backpressure.
        stall_wr = 5;
        run_cmd(32'h10, 32'h180, 2, 1'b0, 1'b0, 1'b0);

        // Domain tagging, with one wrong-domain response injected.
        bad_dom = 1'b1;
        run_cmd(32'h4000, 32'h5000, 2, 1'b1, 1'b1, BAD_DOM_ERR);
        run_cmd(32'h4010, 32'h5010, 1, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of a read, then a stale response drained in IDLE.
        rdy_pct = 100; max_delay = 0; hold_resp = 1;
        start_cmd(32'h200, 32'h300, 2, 1'b0);
        for (int k = 0; k < 50 && resp_q.size() == 0; k++) step();
        check("abort_rd_fired", 64'(resp_q.size()), 64'(1));
        step();
        check("abort_in_rd_resp", 64'(memresp_rdy), 64'(1));
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        exp_q.delete();
        check("abort_idle_rdy", 64'(cmd_rdy), 64'(1));
        check("abort_idle_resp_rdy", 64'(memresp_rdy), 64'(1));
        hold_resp = 0;
        repeat (6) step();
        check("stale_drained", 64'(resp_q.size()), 64'(0));
        check("abort_no_done", 64'(done_cnt - done0), 64'(0));
        check("abort_no_write", 64'(mem.exists(32'h300)), 64'(0));
        run_cmd(32'h500, 32'h600, 1, 1'b0, 1'b1, 1'b0);

        // Source address wrap past the top of the address space.
        run_cmd(32'hFFFF_FFFC, 32'h700, 2, 1'b0, 1'b1, 1'b0);

        // Randomized commands under random ready/latency.
        for (int t = 0; t < 10; t++) begin
            rdy_pct   = int'($urandom_range(100, 30));
            max_delay = int'($urandom_range(3));
            stall_wr  = int'($urandom_range(3));
            run_cmd(32'h1000 + A'(4 * $urandom_range(63)), 32'h2000 + A'(4 * $urandom_range(63)),
                    int'($urandom_range(6, 1)), 1'($urandom_range(1)), 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
